pipelined_mac_unit: RTL
=======================

# pipelined_mac_unit

Parametrised pipelined multiply-accumulate unit, the successor to the fixed 16x16 pipelined multiplier core used in the feature-extraction datapath. It provides configurable operand widths, signedness and pipeline depth, valid/last sideband tracking, and an optional grouped accumulation mode with wrap or saturate overflow handling. It feeds per-region feature sums, such as colour-channel dot products, to the classifier stage.

## Interface
Parameters:
- ASIZE, 16, operand a width (2..72)
- BSIZE, 16, operand b width (2..72)
- A_SIGNED, 0, 1 = a is two's complement
- B_SIGNED, 0, 1 = b is two's complement
- PIPE_STAGES, 3, product latency in ce-qualified cycles (1..5)
- ACC_SIZE, 40, accumulator width; must be >= ASIZE+BSIZE
- SATURATE, 0, 1 = clamp accumulator on overflow; 0 = wrap

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; 0 freezes all state
- clr  in  1  synchronous flush of the pipeline and the accumulator
- in_valid  in  1  a/b beat valid
- in_last  in  1  last beat of an accumulation group
- acc_en  in  1  1 = beat joins the accumulation; 0 = multiply only
- a  in  ASIZE  operand a
- b  in  BSIZE  operand b
- p_valid  out  1  product valid pulse
- p  out  ASIZE+BSIZE  product
- acc_valid  out  1  group-sum valid pulse
- acc  out  ACC_SIZE  group sum
- acc_ovf  out  1  overflow occurred in the group just reported

## Operation
- PSIZE = ASIZE+BSIZE.
- The product is signed when A_SIGNED or B_SIGNED is 1. Each operand is extended per its own signedness before the multiply, so mixed-sign products are exact.
- in_valid, in_last and acc_en travel through the pipeline alongside the data. A beat with in_valid=0 never affects p_valid or acc.
- Accumulator register: ACC_SIZE bits, sign-extended from p when the product is signed.
  - On a product beat with acc_en=1, first beat of the group: acc_reg = ext(p).
  - On later beats of the group: acc_reg = acc_reg + ext(p).
- Overflow: any carry out of the signed or unsigned ACC_SIZE range sets the internal ovf_reg.
  - SATURATE=1: the sum clamps to the range limit (max, or min for signed) and stays clamped for the rest of the group.
  - SATURATE=0: the sum wraps.
- Group close: a product beat with acc_en=1 and in_last=1 registers acc and acc_ovf, pulses acc_valid, and marks the next beat as first of a new group. in_last on a beat with acc_en=0 is ignored.
- A beat with acc_en=0 in the middle of a group appears on p only. The accumulator is unchanged.
- A single-beat group (first beat and last beat coincide) gives acc = ext(p).
- clr: clears all pipeline valid bits and the accumulator, and starts a new group. A beat presented in the same cycle as clr is dropped. clr has no effect while ce=0.
- Reset values: p=0, p_valid=0, acc=0, acc_valid=0, acc_ovf=0. All pipeline and accumulator state is 0, and the first-beat flag is set.

## Timing
- All latencies are counted in cycles with ce=1.
- p/p_valid: output PIPE_STAGES cycles after the input beat. p_valid is high for one ce-cycle.
- acc/acc_valid: output PIPE_STAGES+1 cycles after the in_last beat. acc_valid is high for one ce-cycle.
- Throughput: one beat per cycle with no bubbles, including back-to-back groups. The last beat of group N and the first beat of group N+1 may be consecutive.
- ce=0: all registers hold. p_valid and acc_valid are gated to 0 at the output, and p, acc and acc_ovf hold their values. Pulses resume when ce returns high.
- rst_n low at any time: asynchronous clear to the reset values. In-flight beats and partial sums are lost, and the first beat after release starts a new group.
- Full pipeline: the block has no backpressure. The consumer must accept every pulse.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs read 0 immediately. Stream resumes cleanly after release with no stale p_valid.
- Plain multiply (defaults, acc_en=0): a=0xFFFF, b=0xFFFF, one beat -> p=0xFFFE0001 with p_valid exactly 3 cycles later. acc_valid stays 0.
- Grouped sum (defaults): 4 beats of a=1000, b=1000, acc_en=1, in_last on beat 4, back-to-back with a second group of 1 beat (a=2, b=3, last) ->
  - acc=0x3D0900 with acc_valid 4 cycles after beat 4.
  - acc=6 on the next cycle.
- Signed (A_SIGNED=B_SIGNED=1): a=0xFFFD (-3), b=7 -> p=0xFFFFFFEB. A group of that beat plus a=4, b=5 (last) -> acc=-1, all ones at ACC_SIZE=40.
- Saturation (ACC_SIZE=33, SATURATE=1): 3 beats of 0xFFFF*0xFFFF in one group -> acc=0x1FFFFFFFF, acc_ovf=1. The next group of 1x1 -> acc=1, acc_ovf=0.
  - Repeat with SATURATE=0: acc=0x0FFFA0003, acc_ovf=1.
- Stall and clr:
  - Drop ce for 5 cycles mid-group -> identical sums and pulses, shifted by 5 cycles.
  - Assert clr after 2 of 4 beats -> no acc_valid for that group; the subsequent group's sum excludes the pre-clr beats.

Source files
------------

// File: rtl/pipelined_mac_unit.sv
// pipelined_mac_unit: parametrised multiply-accumulate with valid/last sideband,
// grouped accumulation and wrap or saturate overflow handling.
module pipelined_mac_unit #(
    parameter int ASIZE       = 16,
    parameter int BSIZE       = 16,
    parameter int A_SIGNED    = 0,
    parameter int B_SIGNED    = 0,
    parameter int PIPE_STAGES = 3,
    parameter int ACC_SIZE    = 40,
    parameter int SATURATE    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic                     acc_en,
    input  logic [ASIZE-1:0]         a,
    input  logic [BSIZE-1:0]         b,
    output logic                     p_valid,
    output logic [ASIZE+BSIZE-1:0]   p,
    output logic                     acc_valid,
    output logic [ACC_SIZE-1:0]      acc,
    output logic                     acc_ovf
);
    localparam int PSIZE    = ASIZE + BSIZE;
    localparam int S        = PIPE_STAGES;
    localparam int M        = ACC_SIZE - 1;
    localparam bit IS_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam bit SAT      = SATURATE != 0;

    logic signed [PSIZE-1:0] a_ext, b_ext;
    logic [PSIZE-1:0]        prod;
    logic [PSIZE-1:0]        pd [S];
    logic [PSIZE-1:0]        pd_src [S];
    logic [S-1:0]            pv, pl, pe;
    logic [PSIZE-1:0]        p_last;
    logic                    fire, close;
    logic [ACC_SIZE-1:0]     acc_reg, ext_p, sat_val, acc_next;
    logic [ACC_SIZE:0]       sum_w;
    logic                    ovf_reg, first, av, step_ovf, ovf_next;

    // Each operand is widened by its own signedness, so mixed-sign products are exact.
    always_comb begin
        a_ext = PSIZE'(a);
        b_ext = PSIZE'(b);
        if (A_SIGNED != 0) a_ext = PSIZE'($signed(a));
        if (B_SIGNED != 0) b_ext = PSIZE'($signed(b));
    end

    assign prod = PSIZE'(a_ext * b_ext);

    always_comb begin
        pd_src[0] = prod;
        for (int i = 1; i < S; i++) pd_src[i] = pd[i-1];
    end

    // Data stages load only with a valid beat so p holds its last product between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pl <= '0;
            pe <= '0;
            for (int i = 0; i < S; i++) pd[i] <= '0;
        end else if (ce) begin
            pv <= clr ? '0 : S'({pv, in_valid});
            pl <= S'({pl, in_last});
            pe <= S'({pe, acc_en});
            for (int i = 0; i < S; i++)
                if (!clr && S'({pv, in_valid}) >> i & S'(1)) pd[i] <= pd_src[i];
        end
    end

    assign p_last  = pd[S-1];
    assign p       = p_last;
    assign p_valid = pv[S-1] & ce;
    assign fire    = pv[S-1] & pe[S-1];
    assign close   = fire & pl[S-1];

    always_comb begin
        ext_p = ACC_SIZE'(p_last);
        if (IS_SIGNED) ext_p = ACC_SIZE'($signed(p_last));
        sum_w    = {1'b0, acc_reg} + {1'b0, ext_p};
        step_ovf = IS_SIGNED ? (acc_reg[M] == ext_p[M]) && (sum_w[M] != acc_reg[M]) : sum_w[ACC_SIZE];
        sat_val  = !IS_SIGNED ? '1 : acc_reg[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
        acc_next = first ? ext_p :
                   (SAT && ovf_reg) ? acc_reg :
                   (SAT && step_ovf) ? sat_val : sum_w[M:0];
        ovf_next = !first && (ovf_reg || step_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            first   <= 1'b1;
            av      <= 1'b0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (ce) begin
            if (clr) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
                first   <= 1'b1;
                av      <= 1'b0;
            end else begin
                av <= close;
                if (fire) begin
                    acc_reg <= acc_next;
                    ovf_reg <= ovf_next;
                    first   <= pl[S-1];
                end
                if (close) begin
                    acc     <= acc_next;
                    acc_ovf <= ovf_next;
                end
            end
        end
    end

    assign acc_valid = av & ce;
endmodule
